// File: rtl/datapath_pkg.sv
// Shared definitions for the register-file + ALU datapath.
//   DATA_W_DEF / ADDR_W_DEF : default data and register-address widths
//   alu_op_e                : named 3-bit ALU opcodes
package datapath_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

endpackage : datapath_pkg

// File: rtl/dp_alu.sv
// Purely combinational ALU with status flags.
//   a, b      : operands
//   alu_ctrl  : opcode (alu_op_e encoding)
//   result    : operation result
//   zero      : result is all zeros
//   carry     : ADD carry-out, SUB borrow, or the bit shifted out
//   overflow  : two's-complement overflow for ADD/SUB, 0 otherwise
module dp_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              overflow
);

    localparam int MSB = DATA_W - 1;

    // One extra bit captures carry-out of the add and borrow of the subtract.
    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op_e'(alu_ctrl))
            ALU_ADD: begin
                result   = sum_w[MSB:0];
                carry    = sum_w[DATA_W];
                overflow = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result   = diff_w[MSB:0];
                carry    = diff_w[DATA_W];
                overflow = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SLL: begin
                result = {a[MSB-1:0], 1'b0};
                carry  = a[MSB];
            end
            ALU_SRL: begin
                result = {1'b0, a[MSB:1]};
                carry  = a[0];
            end
        endcase
    end

    assign zero = (result == '0);

endmodule : dp_alu

// File: rtl/datapath_top.sv
// Register file (inline) feeding a combinational ALU.
//   clk, rst          : clock; asynchronous active-high reset clearing all registers
//   wen, waddr, wdata : synchronous register write port
//   raddr1, raddr2    : combinational read ports for operands A and B
//   alu_ctrl          : ALU opcode
//   alu_result, zero, carry, overflow : unregistered ALU outputs
module datapath_top
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              carry,
    output logic              overflow
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    always_comb begin
        regs_d = regs_q;
        if (wen) begin
            regs_d[waddr] = wdata;
        end
    end

    // NOTE: the register file is small and its contents are architecturally visible
    // right after reset, so every entry is cleared rather than left uninitialised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: non-blocking assignment for all sequential state.
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads come straight from storage: a same-cycle write is visible only after the edge.
    assign op_a = regs_q[raddr1];
    assign op_b = regs_q[raddr2];

    dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a        (op_a),
        .b        (op_b),
        .alu_ctrl (alu_ctrl),
        .result   (alu_result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
    );

endmodule : datapath_top

// File: tb/tb_datapath_top.sv
// Self-checking bench for datapath_top: directed cases with literal expectations
// plus randomized traffic compared every cycle against an arithmetic reference model.
module tb_datapath_top;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                           OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wen = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr1 = '0;
    logic [2:0] raddr2 = '0;
    logic [2:0] alu_ctrl = OP_ADD;
    logic [7:0] alu_result;
    logic       zero, carry, overflow;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    logic [7:0] model_regs [8];

    datapath_top dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU written as plain integer arithmetic on unsigned/signed values.
    function automatic void model_alu(input int a, input int b, input int op,
                                      output int res, output bit c, output bit v);
        int sa, sb, s;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: begin
                res = (a + b) % 256;
                c = (a + b) > 255;
                s = sa + sb;
                v = (s > 127) || (s < -128);
            end
            1: begin
                res = (a - b + 256) % 256;
                c = a < b;
                s = sa - sb;
                v = (s > 127) || (s < -128);
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 255 - a;
            6: begin res = (a * 2) % 256; c = a >= 128; end
            default: begin res = a / 2; c = (a % 2) == 1; end
        endcase
    endfunction

    // Reference register file: async clear, otherwise write on the rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) model_regs[i] <= 8'h00;
        end else if (wen) begin
            model_regs[waddr] <= wdata;
        end
    end

    // Every-cycle comparison, sampled on the falling edge with inputs stable.
    always @(negedge clk) begin
        if (cmp_en) begin
            int  er;
            bit  ec, ev;
            model_alu(int'(model_regs[raddr1]), int'(model_regs[raddr2]), int'(alu_ctrl), er, ec, ev);
            check("cyc_result",   32'(alu_result), 32'(er));
            check("cyc_zero",     32'(zero),       32'(er == 0));
            check("cyc_carry",    32'(carry),      32'(ec));
            check("cyc_overflow", 32'(overflow),   32'(ev));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        wen = 1'b1;
        waddr = a;
        wdata = d;
        step();
        wen = 1'b0;
    endtask

    task automatic expect_alu(input string name, input logic [2:0] r1, input logic [2:0] r2,
                              input logic [2:0] op, input logic [7:0] res,
                              input logic z, input logic c, input logic v);
        raddr1 = r1;
        raddr2 = r2;
        alu_ctrl = op;
        #1;
        check({name, "_res"}, 32'(alu_result), 32'(res));
        check({name, "_z"},   32'(zero),       32'(z));
        check({name, "_c"},   32'(carry),      32'(c));
        check({name, "_v"},   32'(overflow),   32'(v));
    endtask

    function automatic logic [7:0] pick_data();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state: zero operands through ADD.
        step();
        cmp_en = 1'b1;
        expect_alu("reset_add", 3'd0, 3'd0, OP_ADD, 8'h00, 1'b1, 1'b0, 1'b0);
        wen = 1'b1; waddr = 3'd4; wdata = 8'hAA;
        step();
        wen = 1'b0;
        expect_alu("write_in_reset", 3'd4, 3'd4, OP_OR, 8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        do_write(3'd1, 8'd10);
        do_write(3'd2, 8'd5);
        expect_alu("add_10_5", 3'd1, 3'd2, OP_ADD, 8'd15, 1'b0, 1'b0, 1'b0);
        expect_alu("sub_10_5", 3'd1, 3'd2, OP_SUB, 8'd5,  1'b0, 1'b0, 1'b0);

        do_write(3'd1, 8'd5);
        do_write(3'd2, 8'd10);
        expect_alu("sub_5_10", 3'd1, 3'd2, OP_SUB, 8'd251, 1'b0, 1'b1, 1'b0);

        do_write(3'd1, 8'd200);
        do_write(3'd2, 8'd100);
        expect_alu("add_200_100", 3'd1, 3'd2, OP_ADD, 8'd44, 1'b0, 1'b1, 1'b0);
        do_write(3'd1, 8'd100);
        expect_alu("add_100_100", 3'd1, 3'd2, OP_ADD, 8'd200, 1'b0, 1'b0, 1'b1);

        do_write(3'd1, 8'hF0);
        do_write(3'd2, 8'h0F);
        expect_alu("and_f0_0f", 3'd1, 3'd2, OP_AND, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_alu("or_f0_0f",  3'd1, 3'd2, OP_OR,  8'hFF, 1'b0, 1'b0, 1'b0);
        expect_alu("xor_f0_0f", 3'd1, 3'd2, OP_XOR, 8'hFF, 1'b0, 1'b0, 1'b0);
        expect_alu("not_f0",    3'd1, 3'd2, OP_NOT, 8'h0F, 1'b0, 1'b0, 1'b0);
        expect_alu("sll_f0",    3'd1, 3'd2, OP_SLL, 8'hE0, 1'b0, 1'b1, 1'b0);
        expect_alu("srl_f0",    3'd1, 3'd2, OP_SRL, 8'h78, 1'b0, 1'b0, 1'b0);

        do_write(3'd1, 8'h80);
        do_write(3'd2, 8'h80);
        expect_alu("add_wrap", 3'd1, 3'd2, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b1);
        do_write(3'd0, 8'h33);
        expect_alu("r0_store", 3'd0, 3'd0, OP_AND, 8'h33, 1'b0, 1'b0, 1'b0);

        // Write disabled, then read-during-write without bypass.
        do_write(3'd3, 8'h11);
        wen = 1'b0; waddr = 3'd3; wdata = 8'h55;
        step();
        expect_alu("wen0_hold", 3'd3, 3'd3, OP_AND, 8'h11, 1'b0, 1'b0, 1'b0);
        wen = 1'b1; wdata = 8'h22;
        expect_alu("rdw_before", 3'd3, 3'd3, OP_AND, 8'h11, 1'b0, 1'b0, 1'b0);
        step();
        wen = 1'b0;
        expect_alu("rdw_after", 3'd3, 3'd3, OP_AND, 8'h22, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges, then an immediate write after release.
        do_write(3'd1, 8'd10);
        expect_alu("pre_rst", 3'd1, 3'd1, OP_ADD, 8'd20, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        expect_alu("async_rst", 3'd1, 3'd1, OP_ADD, 8'd0, 1'b1, 1'b0, 1'b0);
        expect_alu("async_rst_r3", 3'd3, 3'd3, OP_OR, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        do_write(3'd1, 8'd7);
        expect_alu("post_rst_wr", 3'd1, 3'd1, OP_ADD, 8'd14, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 500; i++) begin
            rst      = rst ? 1'b0 : ($urandom_range(0, 39) == 0);
            wen      = 1'($urandom_range(0, 1));
            waddr    = 3'($urandom);
            wdata    = pick_data();
            raddr1   = 3'($urandom);
            raddr2   = ($urandom_range(0, 5) == 0) ? raddr1 : 3'($urandom);
            alu_ctrl = 3'($urandom);
            step();
        end
        rst = 1'b0;
        wen = 1'b0;
        step();
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_datapath_top

// File: doc/datapath_top.md
DATAPATH_TOP -- requirements
Module: datapath_top

Interface
REQ-001 Parameter DATA_W, default 8, data width of registers, write data and ALU.
REQ-002 Parameter ADDR_W, default 3, register address width; register count is 2**ADDR_W (8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wen  input  1  register-file write enable.
REQ-006 waddr  input  ADDR_W  write register index.
REQ-007 wdata  input  DATA_W  write data.
REQ-008 raddr1  input  ADDR_W  read index for ALU operand A.
REQ-009 raddr2  input  ADDR_W  read index for ALU operand B.
REQ-010 alu_ctrl  input  3  ALU operation select.
REQ-011 alu_result  output  DATA_W  ALU result.
REQ-012 zero  output  1  high when alu_result == 0.
REQ-013 carry  output  1  carry/borrow/shift-out flag.
REQ-014 overflow  output  1  signed (two's-complement) overflow flag.

Function
REQ-015 Register file SHALL hold 8 registers of DATA_W bits; all registers, including R0, SHALL be ordinary writable storage.
REQ-016 On a rising clk with wen=1 and rst=0, the register at waddr SHALL take wdata; with wen=0, no register SHALL change.
REQ-017 Reads SHALL be combinational: A = reg[raddr1], B = reg[raddr2], with no clock latency.
REQ-018 When a read index equals waddr during a write cycle, the read SHALL return the old value until the edge, then the new value; no bypass.
REQ-019 When raddr1 == raddr2, both operands SHALL carry the same value.
REQ-020 ALU and flags SHALL be purely combinational from A, B and alu_ctrl; outputs are unregistered.
REQ-021 alu_ctrl 000 ADD: result = (A+B) mod 256; carry = bit-8 carry-out; overflow = A,B same sign and result sign differs.
REQ-022 alu_ctrl 001 SUB: result = (A-B) mod 256; carry = 1 iff A < B unsigned (borrow); overflow = A,B differ in sign and result sign differs from A.
REQ-023 alu_ctrl 010 AND, 011 OR, 100 XOR: bitwise on A,B; carry = 0; overflow = 0.
REQ-024 alu_ctrl 101 NOT: result = ~A; carry = 0; overflow = 0.
REQ-025 alu_ctrl 110 SLL: result = A << 1, LSB filled 0; carry = A[7]; overflow = 0.
REQ-026 alu_ctrl 111 SRL: result = A >> 1, MSB filled 0; carry = A[0]; overflow = 0.
REQ-027 zero SHALL be high for every operation whose 8-bit result is 0x00, including a wrapped result (e.g. 0x80+0x80).
REQ-028 No output SHALL be X for any defined input combination; all 8 alu_ctrl codes are defined.

Reset
REQ-029 Asserting rst SHALL immediately, without a clock edge, clear all 8 registers to 0x00.
REQ-030 While rst is high, writes SHALL be ignored regardless of wen.
REQ-031 During and after reset, with no writes, outputs SHALL follow the combinational function on zero operands (e.g. ADD: alu_result=0x00, zero=1, carry=0, overflow=0).
REQ-032 Reset asserted mid-operation SHALL discard all stored values; deassertion SHALL need no extra cycles before writes are accepted.

Structure
REQ-033 A shared package SHALL hold DATA_W/ADDR_W defaults and named constants for the 8 ALU opcodes.
REQ-034 The ALU SHALL be a separate combinational sub-module named dp_alu; the register file SHALL be inline in datapath_top.

Verification
REQ-035 Reset, write R1=10 and R2=5 on consecutive cycles, wen=0, raddr1=1, raddr2=2, ADD -> alu_result=15, zero=0, carry=0, overflow=0; SUB -> 5, flags 0.
REQ-036 R1=5, R2=10, SUB -> alu_result=251, carry=1, overflow=0, zero=0.
REQ-037 R1=200, R2=100, ADD -> 44, carry=1, overflow=0; R1=R2=100, ADD -> 200, overflow=1, carry=0.
REQ-038 R1=0xF0, R2=0x0F: AND -> 0x00 with zero=1; OR -> 0xFF; XOR -> 0xFF; NOT -> 0x0F; SLL -> 0xE0 with carry=1; SRL -> 0x78 with carry=0.
REQ-039 Write R3 with wen=0 -> R3 unchanged; read R3 while writing it -> old value before the edge, new value after.
REQ-040 Assert rst asynchronously between edges after loading R1=10 -> R1 reads 0 immediately; ADD of R1,R1 -> 0 with zero=1.
